// File: rtl/oled_pkg.sv
// Shared constants and state encoding for the OLED text streamer.
package oled_pkg;

    localparam int NUM_CHARS = 64;
    localparam int CHAR_W    = 7;
    localparam int ADDR_W    = $clog2(NUM_CHARS);

    localparam logic [CHAR_W-1:0] BLANK_CHAR = 7'h20;
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_CHARS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_SEND,
        S_WAIT_LOW,
        S_FIN
    } state_e;

endpackage

// File: rtl/oled_text_buffer.sv
// 64-entry character register file: one synchronous write port, one
// combinational read port, reset fills every entry with BLANK_CHAR.
module oled_text_buffer
    import oled_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CHAR_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [CHAR_W-1:0] rdata
);

    logic [NUM_CHARS-1:0][CHAR_W-1:0] mem_q, mem_d;

    // Next contents: current contents with the optional write folded in.
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    // Storage; a read on the write edge still sees the old value.
    always_ff @(posedge clock) begin
        if (reset) mem_q <= {NUM_CHARS{BLANK_CHAR}};
        else       mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/oled_text_streamer.sv
// Holds a 64-character text frame and streams it, one character per
// handshake, to the OLED controller. Also provides a bulk clear to spaces.
module oled_text_streamer
    import oled_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic              clear,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic [CHAR_W-1:0] sendData,
    output logic              sendDataValid,
    input  logic              sendDone
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CHAR_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    logic              buf_we;
    logic [ADDR_W-1:0] buf_waddr;
    logic [CHAR_W-1:0] buf_wdata;
    logic [CHAR_W-1:0] buf_rdata;

    oled_text_buffer u_buf (
        .clock (clock),
        .reset (reset),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (buf_wdata),
        .raddr (idx_q),
        .rdata (buf_rdata)
    );

    // Next-state, index, output-register and buffer write-port control.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        valid_d   = valid_q;
        buf_we    = 1'b0;
        buf_waddr = wr_addr;
        buf_wdata = wr_data;

        case (state_q)
            S_IDLE: begin
                buf_we = wr_en;
                if (clear) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                end else if (start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_CLEAR: begin
                // Host writes are locked out; the port sweeps blanks instead.
                buf_we    = 1'b1;
                buf_waddr = idx_q;
                buf_wdata = BLANK_CHAR;
                if (idx_q == LAST_IDX) state_d = S_IDLE;
                else                   idx_d   = idx_q + ADDR_W'(1);
            end
            S_LOAD: begin
                buf_we  = wr_en;
                data_d  = buf_rdata;
                state_d = S_SEND;
            end
            S_SEND: begin
                buf_we = wr_en;
                // valid is only raised on a cycle with sendDone low, so a
                // high valid doubles as "acknowledge was seen low since entry"
                // and a stale acknowledge can never complete this character.
                if (valid_q && sendDone) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT_LOW;
                end else if (!sendDone) begin
                    valid_d = 1'b1;
                end
            end
            S_WAIT_LOW: begin
                buf_we = wr_en;
                if (!sendDone) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any stream or clear at once.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign frame_done    = (state_q == S_FIN);
    assign sendData      = data_q;
    assign sendDataValid = valid_q;

endmodule

// File: tb/tb_oled_text_streamer.sv
// Directed bench for oled_text_streamer with a behavioural OLED controller.
module tb_oled_text_streamer;
    import oled_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [CHAR_W-1:0] wr_data = '0;
    logic              clear = 1'b0;
    logic              start = 1'b0;
    logic              busy, frame_done, sendDataValid;
    logic [CHAR_W-1:0] sendData;
    logic              ctrl_done = 1'b0;
    logic              sendDone;

    assign sendDone = ctrl_done;

    oled_text_streamer dut (
        .clock         (clock),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .clear         (clear),
        .start         (start),
        .busy          (busy),
        .frame_done    (frame_done),
        .sendData      (sendData),
        .sendDataValid (sendDataValid),
        .sendDone      (sendDone)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Controller model: ack 20 cycles after valid, sendDone held 3 cycles
    // (or long_len cycles for the ack whose running number is long_char).
    int ack_delay = 20;
    int ack_len = 3;
    int long_char = -1;
    int long_len = 10;
    int n_acks = 0;
    int wait_cnt = 0;
    int hi_cnt = 0;
    int long_fall_cyc = 0;
    bit in_long = 1'b0;
    int cyc = 0;

    always @(posedge clock) begin
        #2;
        if (reset) begin
            ctrl_done = 1'b0;
            wait_cnt = 0;
            hi_cnt = 0;
            in_long = 1'b0;
        end else if (hi_cnt > 0) begin
            hi_cnt--;
            if (hi_cnt == 0) begin
                ctrl_done = 1'b0;
                if (in_long) begin
                    long_fall_cyc = cyc;
                    in_long = 1'b0;
                end
            end
        end else if (sendDataValid) begin
            wait_cnt++;
            if (wait_cnt >= ack_delay) begin
                ctrl_done = 1'b1;
                wait_cnt = 0;
                in_long = (n_acks == long_char);
                hi_cnt = in_long ? long_len : ack_len;
                n_acks++;
            end
        end
    end

    // Monitor: records requests and counts protocol violations.
    logic [CHAR_W-1:0] got_q[$];
    int req_cyc[$];
    int fd_cnt = 0;
    int stab_err = 0;
    int raise_err = 0;
    int drop_err = 0;
    int fd_width_err = 0;
    int fd_busy_err = 0;
    logic pv = 1'b0;
    logic pfd = 1'b0;
    logic [CHAR_W-1:0] pd = '0;

    always @(posedge clock) begin
        #1;
        cyc++;
        if (reset) begin
            pv = 1'b0;
            pfd = 1'b0;
        end else begin
            if (sendDataValid && !pv) begin
                got_q.push_back(sendData);
                req_cyc.push_back(cyc);
                if (sendDone) raise_err++;
            end
            if (sendDataValid && pv && sendData !== pd) stab_err++;
            if (!sendDataValid && pv && !sendDone) drop_err++;
            if (frame_done && !pfd) begin
                fd_cnt++;
                if (!busy) fd_busy_err++;
            end
            if (frame_done && pfd) fd_width_err++;
            if (!frame_done && pfd && busy) fd_busy_err++;
            pv = sendDataValid;
            pd = sendData;
            pfd = frame_done;
        end
    end

    logic [CHAR_W-1:0] model[NUM_CHARS];

    task automatic blank_model();
        for (int i = 0; i < NUM_CHARS; i++) model[i] = BLANK_CHAR;
    endtask

    function automatic logic [CHAR_W-1:0] q_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 'x;
    endfunction

    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [CHAR_W-1:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int fd0);
        int t = 0;
        while (fd_cnt == fd0 && t < 5000) begin
            @(negedge clock);
            t++;
        end
        check({name, "_done"}, fd_cnt - fd0, 1);
        @(negedge clock);
        check({name, "_idle"}, busy, 1'b0);
    endtask

    task automatic run_frame(input string name);
        int fd0;
        got_q.delete();
        req_cyc.delete();
        fd0 = fd_cnt;
        pulse_start();
        wait_frame(name, fd0);
    endtask

    task automatic wait_reqs(input string name, input int n);
        int t = 0;
        while (got_q.size() < n && t < 3000) begin
            @(negedge clock);
            t++;
        end
        check({name, "_reached"}, got_q.size() >= n, 1'b1);
    endtask

    task automatic compare_frame(input string name);
        int bad = 0;
        check({name, "_count"}, got_q.size(), NUM_CHARS);
        for (int i = 0; i < NUM_CHARS; i++)
            if (q_at(i) !== model[i]) bad++;
        check({name, "_data"}, bad, 0);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [CHAR_W-1:0] data;
        logic [CHAR_W-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int fd0;
        int n;

        vecs[0] = '{6'd0,  7'h48, 7'h48};
        vecs[1] = '{6'd1,  7'h45, 7'h45};
        vecs[2] = '{6'd2,  7'h4C, 7'h4C};
        vecs[3] = '{6'd3,  7'h4C, 7'h4C};
        vecs[4] = '{6'd4,  7'h4F, 7'h4F};
        vecs[5] = '{6'd63, 7'h5A, 7'h5A};

        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        blank_model();
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_valid", sendDataValid, 1'b0);
        check("rst_data", sendData, 7'h00);

        // Blank frame with start-to-valid latency
        got_q.delete();
        req_cyc.delete();
        fd0 = fd_cnt;
        pulse_start();
        check("lat_busy", busy, 1'b1);
        check("lat_valid_n1", sendDataValid, 1'b0);
        @(negedge clock);
        check("lat_valid_n2", sendDataValid, 1'b0);
        @(negedge clock);
        check("lat_valid_n3", sendDataValid, 1'b1);
        wait_frame("blank", fd0);
        compare_frame("blank");

        // HELLO ... Z from the vector table
        for (int i = 0; i < 6; i++) begin
            host_write(vecs[i].addr, vecs[i].data);
            model[vecs[i].addr] = vecs[i].data;
        end
        run_frame("hello");
        compare_frame("hello");
        for (int i = 0; i < 6; i++)
            check($sformatf("hello_chr%0d", vecs[i].addr), q_at(int'(vecs[i].addr)), vecs[i].exp);

        // Long acknowledge on character 5
        long_char = n_acks + 5;
        run_frame("hold");
        long_char = -1;
        compare_frame("hold");
        check("hold_next_after_fall", req_cyc.size() > 6 && req_cyc[6] > long_fall_cyc, 1'b1);
        check("hold_gap", req_cyc.size() > 6 && (req_cyc[6] - req_cyc[5]) >= 30, 1'b1);

        // clear and start together, start and write during the clear
        got_q.delete();
        clear = 1'b1;
        start = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            start = (n == 10);
            wr_en = (n == 20);
            wr_addr = 6'd3;
            wr_data = 7'h51;
            @(negedge clock);
        end
        start = 1'b0;
        wr_en = 1'b0;
        check("clear_busy_cycles", n, 64);
        repeat (5) @(negedge clock);
        check("clear_start_ignored", busy, 1'b0);
        check("clear_no_valid", got_q.size(), 0);
        blank_model();
        run_frame("clear");
        compare_frame("clear");

        // Reset while character 30 is in flight
        host_write(6'd50, 7'h4B);
        model[50] = 7'h4B;
        got_q.delete();
        pulse_start();
        wait_reqs("rst30", 31);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst30_valid", sendDataValid, 1'b0);
        check("rst30_busy", busy, 1'b0);
        check("rst30_data", sendData, 7'h00);
        check("rst30_frame_done", frame_done, 1'b0);
        blank_model();
        host_write(6'd0, 7'h41);
        host_write(6'd1, 7'h42);
        model[0] = 7'h41;
        model[1] = 7'h42;
        run_frame("after_rst");
        compare_frame("after_rst");

        // Writes while character 9 is in SEND
        got_q.delete();
        req_cyc.delete();
        fd0 = fd_cnt;
        pulse_start();
        wait_reqs("inflight", 10);
        check("inflight_valid", sendDataValid, 1'b1);
        host_write(6'd10, 7'h4E);
        host_write(6'd9, 7'h4D);
        check("inflight_data_held", sendData, 7'h20);
        model[10] = 7'h4E;
        wait_frame("inflight", fd0);
        compare_frame("inflight");
        check("inflight_chr9", q_at(9), 7'h20);
        check("inflight_chr10", q_at(10), 7'h4E);
        model[9] = 7'h4D;
        run_frame("final");
        compare_frame("final");

        // Protocol invariants across the whole run
        check("stable_data", stab_err, 0);
        check("raise_while_done", raise_err, 0);
        check("drop_without_done", drop_err, 0);
        check("frame_done_width", fd_width_err, 0);
        check("frame_done_busy", fd_busy_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
